demux8_buf_rtl: RTL and testbench

DEMUX8_BUF_RTL -- requirements
Module: demux8_buf_rtl

---
 rtl/demux8_buf_rtl.sv | 94 +++++++++
 tb/tb_demux8_buf_rtl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/demux8_buf_rtl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux8_buf_rtl: 2-entry buffered 1-to-8 demux with valid/ready handshakes.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module demux8_buf_rtl #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  logic [2:0]         in_sel,
  output logic [7:0]         out_val,
  input  logic [7:0]         out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [1:0]         count
);

  localparam logic [1:0] c_full = 2'd2;

  logic [2:0]         entry_sel_q [0:1];
  logic [2:0]         entry_sel_d [0:1];
  logic [p_nbits-1:0] entry_msg_q [0:1];
  logic [p_nbits-1:0] entry_msg_d [0:1];
  logic               enq_ptr_q, enq_ptr_d;
  logic               deq_ptr_q, deq_ptr_d;
  logic [1:0]         count_q, count_d;

  logic               w_enq;
  logic               w_deq;
  logic [2:0]         w_head_sel;
  logic [p_nbits-1:0] w_head_msg;

  always_comb begin
    w_head_sel = entry_sel_q[deq_ptr_q];
    w_head_msg = entry_msg_q[deq_ptr_q];

    // in_rdy looks only at occupancy; a full buffer never bypasses on out_rdy.
    in_rdy = (count_q != c_full);
    w_enq  = in_val && in_rdy;
    w_deq  = (count_q != 2'd0) && out_rdy[w_head_sel];

    out_val = 8'h00;
    out_msg = '0;
    if (count_q != 2'd0) begin
      out_val[w_head_sel] = 1'b1;
      out_msg             = w_head_msg;
    end

    entry_sel_d = entry_sel_q;
    entry_msg_d = entry_msg_q;
    enq_ptr_d   = enq_ptr_q;
    deq_ptr_d   = deq_ptr_q;
    count_d     = count_q;

    if (w_enq) begin
      entry_sel_d[enq_ptr_q] = in_sel;
      entry_msg_d[enq_ptr_q] = in_msg;
      enq_ptr_d              = ~enq_ptr_q;
    end
    if (w_deq) begin
      deq_ptr_d = ~deq_ptr_q;
    end
    case ({w_enq, w_deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enq_ptr_q <= 1'b0;
      deq_ptr_q <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    entry_sel_q <= entry_sel_d;
    entry_msg_q <= entry_msg_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux8_buf_rtl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux8_buf_rtl: directed and scoreboarded checks for demux8_buf_rtl.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_demux8_buf_rtl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic [2:0]  in_sel;
  logic [7:0]  out_val;
  logic [7:0]  out_rdy;
  logic [31:0] out_msg;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  demux8_buf_rtl #(.p_nbits(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .in_sel  (in_sel),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] e_cnt,
                           input logic [7:0] e_val, input logic [31:0] e_msg);
    chk({tag, ".count"}, 64'(count), 64'(e_cnt));
    chk({tag, ".out_val"}, 64'(out_val), 64'(e_val));
    chk({tag, ".out_msg"}, 64'(out_msg), 64'(e_msg));
    chk({tag, ".in_rdy"}, 64'(in_rdy), 64'(e_cnt != 2'd2));
  endtask

  logic [34:0] q[$];
  logic [34:0] head;
  logic        m_enq, m_deq;
  logic [7:0]  e_val;
  logic [31:0] e_msg;

  initial begin
    rst = 1'b1; in_val = 1'b0; in_msg = '0; in_sel = '0; out_rdy = 8'h00;
    tick(); tick();
    chk_state("reset", 2'd0, 8'h00, 32'h0);

    // single message to port 5, one-cycle latency
    rst = 1'b0;
    in_val = 1'b1; in_sel = 3'd5; in_msg = 32'hDEADBEEF; out_rdy = 8'hFF;
    chk_state("pre_enq", 2'd0, 8'h00, 32'h0);
    tick();
    in_val = 1'b0;
    chk_state("single", 2'd1, 8'h20, 32'hDEADBEEF);
    tick();
    chk_state("single_drain", 2'd0, 8'h00, 32'h0);

    // fill with A, B; C held off by in_rdy
    out_rdy = 8'h00;
    in_val = 1'b1; in_sel = 3'd0; in_msg = 32'hAAAA_0000; tick();
    chk_state("fill_a", 2'd1, 8'h01, 32'hAAAA_0000);
    in_sel = 3'd7; in_msg = 32'hBBBB_0007; tick();
    chk_state("fill_b", 2'd2, 8'h01, 32'hAAAA_0000);
    in_sel = 3'd3; in_msg = 32'hCCCC_0003; tick();
    chk_state("hold_c", 2'd2, 8'h01, 32'hAAAA_0000);
    in_val = 1'b0;

    // non-selected ready ignored, then head released
    out_rdy = 8'h80; tick();
    chk_state("hol_block", 2'd2, 8'h01, 32'hAAAA_0000);
    out_rdy = 8'h01; tick();
    chk_state("deliver_a", 2'd1, 8'h80, 32'hBBBB_0007);

    // simultaneous enq/deq at count=1, sel cycling
    out_rdy = 8'hFF; in_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sel = 3'(i % 8);
      in_msg = 32'h100 + 32'(i);
      tick();
      chk_state($sformatf("stream%0d", i), 2'd1, 8'h01 << (i % 8), 32'h100 + 32'(i));
    end
    in_val = 1'b0; tick();
    chk_state("stream_drain", 2'd0, 8'h00, 32'h0);

    // mid-operation reset with in_val asserted
    out_rdy = 8'h00; in_val = 1'b1; in_sel = 3'd2; in_msg = 32'h1111;
    tick(); tick();
    chk_state("pre_rst", 2'd2, 8'h04, 32'h1111);
    rst = 1'b1; tick();
    chk_state("mid_rst", 2'd0, 8'h00, 32'h0);
    rst = 1'b0; in_val = 1'b0; tick();
    chk_state("post_rst", 2'd0, 8'h00, 32'h0);

    // random traffic against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_val  = 1'($urandom_range(0, 1));
      in_sel  = 3'($urandom_range(0, 7));
      in_msg  = $urandom;
      out_rdy = 8'($urandom);
      e_val = 8'h00;
      e_msg = 32'h0;
      if (q.size() != 0) begin
        head  = q[0];
        e_val = 8'h01 << head[34:32];
        e_msg = head[31:0];
      end
      chk("rnd.onehot0", 64'($onehot0(out_val)), 64'd1);
      chk_state("rnd", 2'(q.size()), e_val, e_msg);
      m_enq = in_val && (q.size() != 2);
      m_deq = (q.size() != 0) && out_rdy[q[0][34:32]];
      tick();
      if (m_deq) void'(q.pop_front());
      if (m_enq) q.push_back({in_sel, in_msg});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
